display_scheduler: RTL and testbench

Time-multiplexes up to N_SRC 8-bit game values (score, level, note, etc.) onto the single numero input of the 7-segment conversion path. Sources take turns round-robin, and each is shown for a fixed dwell period. A requester can pre-empt the rotation through a req/ack handshake to flash a one-off value for a fixed hold period. Sits between the game datapath and the display converter, in the same clock domain.

---
 rtl/display_sched_pkg.sv | 18 +
 rtl/display_scheduler_seletor_proximo.sv | 28 ++
 rtl/display_scheduler.sv | 138 +++++++++++++
 tb/tb_display_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/display_sched_pkg.sv
// Shared types and reset values for the display scheduler.
package display_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROTATE   = 2'd1,
    OVERRIDE = 2'd2
  } state_t;

  localparam int N_SRC_DEF = 4;
  localparam int FW        = $clog2(N_SRC_DEF);

  localparam state_t RST_STATE  = IDLE;
  localparam logic   RST_VAZIO  = 1'b1;
  localparam logic   RST_EM_OVR = 1'b0;
  localparam logic   RST_ACK    = 1'b0;

endpackage

// File: rtl/display_scheduler_seletor_proximo.sv
// Circular priority finder: first set bit of mask at or after start, wrapping.
module seletor_proximo #(
  parameter int N_SRC = 4,
  parameter int FS    = 2
) (
  input  logic [N_SRC-1:0] mask,
  input  logic [FS-1:0]    start,
  output logic [FS-1:0]    idx,
  output logic             found
);

  logic [FS-1:0] pos;

  // Scan from the far end backwards so the closest hit to start is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      pos = FS'((int'(start) + k) % N_SRC);
      if (mask[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin display source scheduler with a req/ack override that pre-empts
// the rotation for a fixed hold period.
module display_scheduler
  import display_sched_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int W        = 8,
  parameter int DWELL    = 50000000,
  parameter int OVR_HOLD = 100000000,
  localparam int FS      = $clog2(N_SRC)
) (
  input  logic               clock,
  input  logic               zera_as_n,
  input  logic               enable,
  input  logic [N_SRC*W-1:0] valores,
  input  logic [N_SRC-1:0]   ativo,
  input  logic               ovr_req,
  input  logic [W-1:0]       ovr_valor,
  output logic               ovr_ack,
  output logic [W-1:0]       numero,
  output logic [FS-1:0]      fonte,
  output logic               em_override,
  output logic               vazio,
  output state_t             estado
);

  localparam int DW = $clog2(DWELL);
  localparam int HW = $clog2(OVR_HOLD);

  logic [DW-1:0] dwell_cnt;
  logic [HW-1:0] hold_cnt;
  logic [W-1:0]  ovr_lat;
  logic [W-1:0]  val_atual;
  logic [FS-1:0] start_idx;
  logic [FS-1:0] prox;
  logic          achou;
  logic          aceita;

  // Handshake: the requester holds ovr_req (with ovr_valor) until it sees
  // ovr_ack; a request is taken whenever ovr_req=1 and ovr_ack is low, so the
  // one-cycle ack pulse itself masks the still-held request.
  assign aceita    = ovr_req && !ovr_ack;
  assign val_atual = valores[int'(fonte)*W +: W];
  assign start_idx = (estado == IDLE)              ? '0 :
                     (fonte == FS'(N_SRC - 1))     ? '0 : fonte + 1'b1;

  seletor_proximo #(.N_SRC(N_SRC), .FS(FS)) u_sel (
    .mask  (ativo),
    .start (start_idx),
    .idx   (prox),
    .found (achou)
  );

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      estado      <= RST_STATE;
      fonte       <= '0;
      numero      <= '0;
      vazio       <= RST_VAZIO;
      em_override <= RST_EM_OVR;
      ovr_ack     <= RST_ACK;
      dwell_cnt   <= '0;
      hold_cnt    <= '0;
      ovr_lat     <= '0;
    end else begin
      ovr_ack <= aceita;
      if (aceita) begin
        // Override wins over any rotation event in the same cycle.
        ovr_lat     <= ovr_valor;
        hold_cnt    <= '0;
        estado      <= OVERRIDE;
        numero      <= ovr_valor;
        em_override <= 1'b1;
        vazio       <= 1'b0;
      end else begin
        case (estado)
          IDLE: begin
            numero      <= '0;
            vazio       <= 1'b1;
            em_override <= 1'b0;
            if (achou) begin
              fonte     <= prox;
              dwell_cnt <= '0;
              vazio     <= 1'b0;
              estado    <= ROTATE;
            end
          end
          ROTATE: begin
            em_override <= 1'b0;
            if (ativo == '0) begin
              estado    <= IDLE;
              numero    <= '0;
              vazio     <= 1'b1;
              dwell_cnt <= '0;
            end else begin
              numero <= val_atual;
              vazio  <= 1'b0;
              if (!ativo[fonte]) begin
                fonte     <= prox;
                dwell_cnt <= '0;
              end else if (enable) begin
                if (dwell_cnt == DW'(DWELL - 1)) begin
                  fonte     <= prox;
                  dwell_cnt <= '0;
                end else begin
                  dwell_cnt <= dwell_cnt + 1'b1;
                end
              end
            end
          end
          OVERRIDE: begin
            if (hold_cnt == HW'(OVR_HOLD - 1)) begin
              hold_cnt    <= '0;
              dwell_cnt   <= '0;
              em_override <= 1'b0;
              if (ativo == '0) begin
                estado <= IDLE;
                numero <= '0;
                vazio  <= 1'b1;
              end else begin
                estado <= ROTATE;
                numero <= val_atual;
                vazio  <= 1'b0;
              end
            end else begin
              hold_cnt    <= hold_cnt + 1'b1;
              numero      <= ovr_lat;
              em_override <= 1'b1;
              vazio       <= 1'b0;
            end
          end
          default: estado <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: per-cycle expected outputs are queued by
// the driver and checked by an independent monitor on the falling edge.
module tb_display_scheduler;
  import display_sched_pkg::*;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DWELL = 4;
  localparam int HOLD  = 6;
  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_R = 2'd1;
  localparam logic [1:0] S_O = 2'd2;

  logic           clock = 1'b0;
  logic           zera_as_n;
  logic           enable;
  logic [N*W-1:0] valores;
  logic [N-1:0]   ativo;
  logic           ovr_req;
  logic [W-1:0]   ovr_valor;
  logic           ovr_ack;
  logic [W-1:0]   numero;
  logic [1:0]     fonte;
  logic           em_override;
  logic           vazio;
  state_t         estado;

  typedef struct packed {
    logic [7:0]   tag;
    logic [W-1:0] numero;
    logic [1:0]   fonte;
    logic         vazio;
    logic         em_ovr;
    logic         ack;
    logic [1:0]   st;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] step = 8'd0;

  display_scheduler #(.N_SRC(N), .W(W), .DWELL(DWELL), .OVR_HOLD(HOLD)) dut (
    .clock       (clock),
    .zera_as_n   (zera_as_n),
    .enable      (enable),
    .valores     (valores),
    .ativo       (ativo),
    .ovr_req     (ovr_req),
    .ovr_valor   (ovr_valor),
    .ovr_ack     (ovr_ack),
    .numero      (numero),
    .fonte       (fonte),
    .em_override (em_override),
    .vazio       (vazio),
    .estado      (estado)
  );

  // Clock and reset
  always #5 clock = ~clock;

  // Scoreboard compare
  task automatic compare(input exp_t e);
    logic ok;
    ok = (numero == e.numero) && (fonte == e.fonte) && (vazio == e.vazio) &&
         (em_override == e.em_ovr) && (ovr_ack == e.ack) && (estado == e.st);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL step_%0d: got numero=%0d fonte=%0d vazio=%b em_override=%b ovr_ack=%b estado=%0d, expected numero=%0d fonte=%0d vazio=%b em_override=%b ovr_ack=%b estado=%0d",
               e.tag, numero, fonte, vazio, em_override, ovr_ack, estado,
               e.numero, e.fonte, e.vazio, e.em_ovr, e.ack, e.st);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare(e);
    end
  end

  // Driver tasks: push the expectation for the next edge, then move to negedge+1
  task automatic cyc(input logic [W-1:0] n, input logic [1:0] f, input logic v,
                     input logic o, input logic a, input logic [1:0] s);
    exp_t e;
    e = '{tag: step, numero: n, fonte: f, vazio: v, em_ovr: o, ack: a, st: s};
    step = step + 8'd1;
    exp_q.push_back(e);
    @(negedge clock);
    #1;
  endtask

  task automatic rot(input logic [W-1:0] n, input logic [1:0] f, input int reps);
    for (int i = 0; i < reps; i++) cyc(n, f, 1'b0, 1'b0, 1'b0, S_R);
  endtask

  task automatic ovr(input logic [W-1:0] n, input logic [1:0] f, input logic a, input int reps);
    for (int i = 0; i < reps; i++) cyc(n, f, 1'b0, 1'b1, a, S_O);
  endtask

  initial begin
    exp_t rst_e;
    zera_as_n = 1'b0;
    enable    = 1'b1;
    ativo     = 4'b1111;
    valores   = {8'd40, 8'd30, 8'd20, 8'd10};
    ovr_req   = 1'b0;
    ovr_valor = '0;
    @(negedge clock);
    #1;
    cyc(8'd0, 2'd0, 1'b1, 1'b0, 1'b0, S_I);
    zera_as_n = 1'b1;

    // 1: full rotation, 4 cycles per source, numero lags fonte by one cycle
    rot(8'd0, 2'd0, 1);
    rot(8'd10, 2'd0, 3);
    rot(8'd10, 2'd1, 1); rot(8'd20, 2'd1, 3);
    rot(8'd20, 2'd2, 1); rot(8'd30, 2'd2, 3);
    rot(8'd30, 2'd3, 1); rot(8'd40, 2'd3, 3);
    rot(8'd40, 2'd0, 1); rot(8'd10, 2'd0, 1);

    // 2: sparse mask, source drop mid-dwell, mask cleared
    ativo = 4'b1010;
    rot(8'd10, 2'd1, 1); rot(8'd20, 2'd1, 3);
    rot(8'd20, 2'd3, 1); rot(8'd40, 2'd3, 3);
    rot(8'd40, 2'd1, 1); rot(8'd20, 2'd1, 3);
    rot(8'd20, 2'd3, 1); rot(8'd40, 2'd3, 1);
    ativo = 4'b0010;
    rot(8'd40, 2'd1, 1); rot(8'd20, 2'd1, 1);
    ativo = 4'b0000;
    cyc(8'd0, 2'd1, 1'b1, 1'b0, 1'b0, S_I);
    cyc(8'd0, 2'd1, 1'b1, 1'b0, 1'b0, S_I);

    // 3: enable low freezes the dwell; live value still tracked
    ativo = 4'b1111;
    rot(8'd0, 2'd0, 1); rot(8'd10, 2'd0, 1);
    enable = 1'b0;
    rot(8'd10, 2'd0, 4);
    valores[7:0] = 8'd99;
    rot(8'd99, 2'd0, 6);
    valores[7:0] = 8'd10;
    enable = 1'b1;
    rot(8'd10, 2'd0, 2);
    rot(8'd10, 2'd1, 1); rot(8'd20, 2'd1, 3);
    rot(8'd20, 2'd2, 1); rot(8'd30, 2'd2, 2);

    // 4: held request at fonte=2 timer=2, single ack, full dwell afterwards
    ovr_req = 1'b1; ovr_valor = 8'd200;
    ovr(8'd200, 2'd2, 1'b1, 1);
    ovr(8'd200, 2'd2, 1'b0, 1);
    ovr_req = 1'b0; ovr_valor = 8'd0;
    ovr(8'd200, 2'd2, 1'b0, 4);
    rot(8'd30, 2'd2, 4);
    rot(8'd30, 2'd3, 1); rot(8'd40, 2'd3, 1);

    // 5: retrigger at hold count 4, then a request coinciding with dwell expiry
    ovr_req = 1'b1; ovr_valor = 8'd150;
    ovr(8'd150, 2'd3, 1'b1, 1);
    ovr(8'd150, 2'd3, 1'b0, 1);
    ovr_req = 1'b0;
    ovr(8'd150, 2'd3, 1'b0, 3);
    ovr_req = 1'b1; ovr_valor = 8'd77;
    ovr(8'd77, 2'd3, 1'b1, 1);
    ovr(8'd77, 2'd3, 1'b0, 1);
    ovr_req = 1'b0;
    ovr(8'd77, 2'd3, 1'b0, 4);
    rot(8'd40, 2'd3, 4);
    ovr_req = 1'b1; ovr_valor = 8'd55;
    ovr(8'd55, 2'd3, 1'b1, 1);
    ovr(8'd55, 2'd3, 1'b0, 1);
    ovr_req = 1'b0;
    ovr(8'd55, 2'd3, 1'b0, 2);

    // 6: asynchronous reset between edges mid-override
    zera_as_n = 1'b0;
    ativo     = 4'b1100;
    #2;
    rst_e = '{tag: 8'hFF, numero: 8'd0, fonte: 2'd0, vazio: 1'b1, em_ovr: 1'b0, ack: 1'b0, st: S_I};
    compare(rst_e);
    #1;
    zera_as_n = 1'b1;
    rot(8'd0, 2'd2, 1);
    rot(8'd30, 2'd2, 2);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
